// File: rtl/hilo_unit.sv
// HI/LO architectural register pair with mult/div completion tracking and MF/MT access.
// Define HILO_FWD_EN to enable the commit-cycle and same-cycle MT-to-MF bypass paths.
module hilo_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LAT   = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             issue_valid_i,
  input  logic [3:0]       issue_op_i,
  input  logic [WIDTH-1:0] dmu_hi_i,
  input  logic [WIDTH-1:0] dmu_lo_i,
  input  logic             dmu_stall_i,
  input  logic             mthi_i,
  input  logic             mtlo_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             mf_req_i,
  input  logic             mf_sel_i,
  output logic [WIDTH-1:0] mf_data_o,
  output logic             mf_stall_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy_o
);

  localparam int unsigned CntW = $clog2(LAT + 1);

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic op_valid;
  logic accept;
  logic commit;
  logic busy;

  assign op_valid = (issue_op_i == 4'd5) || (issue_op_i == 4'd6) ||
                    (issue_op_i == 4'd11) || (issue_op_i == 4'd7);
  assign accept   = issue_valid_i && op_valid && !dmu_stall_i;
  assign busy     = (cnt_q != '0);
  // A same-edge accept restarts the op, so the older result never lands.
  assign commit   = (cnt_q == CntW'(1)) && !dmu_stall_i && !accept;

  always_comb begin
    cnt_d = cnt_q;
    hi_d  = hi_q;
    lo_d  = lo_q;

    if (accept) begin
      cnt_d = CntW'(LAT);
    end else if (mthi_i || mtlo_i) begin
      cnt_d = '0;
    end else if (busy && !dmu_stall_i) begin
      cnt_d = cnt_q - CntW'(1);
    end

    // MT writes beat the commit per register; the untouched register still commits.
    if (mthi_i) begin
      hi_d = wdata_i;
    end else if (commit) begin
      hi_d = dmu_hi_i;
    end

    if (mtlo_i) begin
      lo_d = wdata_i;
    end else if (commit) begin
      lo_d = dmu_lo_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

  always_comb begin
    mf_data_o  = mf_sel_i ? hi_q : lo_q;
    mf_stall_o = mf_req_i && busy;
`ifdef HILO_FWD_EN
    mf_stall_o = mf_req_i && busy && !commit;
    if (mf_req_i) begin
      if (mf_sel_i) begin
        if (mthi_i) begin
          mf_data_o = wdata_i;
        end else if (commit) begin
          mf_data_o = dmu_hi_i;
        end
      end else begin
        if (mtlo_i) begin
          mf_data_o = wdata_i;
        end else if (commit) begin
          mf_data_o = dmu_lo_i;
        end
      end
    end
`endif
  end

  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
  assign busy_o = busy;

endmodule

// File: tb/tb_hilo_unit.sv
// Directed self-checking bench for hilo_unit; expected values are hand-computed constants.
module tb_hilo_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [3:0]  issue_op;
  logic [31:0] dmu_hi, dmu_lo;
  logic        dmu_stall;
  logic        mthi, mtlo;
  logic [31:0] wdata;
  logic        mf_req, mf_sel;
  logic [31:0] mf_data;
  logic        mf_stall;
  logic [31:0] hi, lo;
  logic        busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hilo_unit #(.WIDTH(32), .LAT(5)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .issue_valid_i(issue_valid),
    .issue_op_i   (issue_op),
    .dmu_hi_i     (dmu_hi),
    .dmu_lo_i     (dmu_lo),
    .dmu_stall_i  (dmu_stall),
    .mthi_i       (mthi),
    .mtlo_i       (mtlo),
    .wdata_i      (wdata),
    .mf_req_i     (mf_req),
    .mf_sel_i     (mf_sel),
    .mf_data_o    (mf_data),
    .mf_stall_o   (mf_stall),
    .hi_o         (hi),
    .lo_o         (lo),
    .busy_o       (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op);
    issue_valid = 1'b1;
    issue_op    = op;
    tick();
    issue_valid = 1'b0;
    issue_op    = 4'd0;
  endtask

  initial begin
    rst = 1'b1; issue_valid = 1'b0; issue_op = 4'd0;
    dmu_hi = 32'h0; dmu_lo = 32'h0; dmu_stall = 1'b0;
    mthi = 1'b0; mtlo = 1'b0; wdata = 32'h0; mf_req = 1'b0; mf_sel = 1'b0;

    // Reset
    tick(); tick();
    rst = 1'b0;
    mf_req = 1'b1;
    #1;
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_mf_stall", {31'b0, mf_stall}, 32'h0);
    check("rst_mf_data", mf_data, 32'h0);
    mf_req = 1'b0;

    // Mult, no stall: junk on dmu outputs until cnt == 1
    dmu_hi = 32'hDEAD_0001; dmu_lo = 32'hDEAD_0002;
    issue(4'd5);                                    // E0
    for (int i = 1; i <= 4; i++) begin
      check("mult_busy", {31'b0, busy}, 32'h1);
      check("mult_hi_hold", hi, 32'h0);
      if (i == 1) begin
        mf_req = 1'b1; mf_sel = 1'b0; #1;
        check("mult_mf_stall", {31'b0, mf_stall}, 32'h1);
        mf_req = 1'b0;
      end
      tick();                                       // E1..E4
    end
    check("mult_busy_last", {31'b0, busy}, 32'h1);
    dmu_hi = 32'hFFFF_FFFF; dmu_lo = 32'hFFFF_FFFA;
    tick();                                         // E5
    dmu_hi = 32'hDEAD_0003; dmu_lo = 32'hDEAD_0004;
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFA);
    check("mult_busy_done", {31'b0, busy}, 32'h0);
    tick();
    check("mult_hi_keep", hi, 32'hFFFF_FFFF);

    // Div with 28 stalled edges: commit at E33
    dmu_hi = 32'h1; dmu_lo = 32'h3;
    issue(4'd11);                                   // E0
    tick(); tick();                                 // E1, E2
    dmu_stall = 1'b1;
    for (int i = 0; i < 28; i++) tick();            // E3..E30
    check("div_busy_stall", {31'b0, busy}, 32'h1);
    check("div_lo_stall", lo, 32'hFFFF_FFFA);
    dmu_stall = 1'b0;
    tick(); tick();                                 // E31, E32
    check("div_busy_e32", {31'b0, busy}, 32'h1);
    check("div_lo_e32", lo, 32'hFFFF_FFFA);
    tick();                                         // E33
    check("div_lo", lo, 32'h3);
    check("div_hi", hi, 32'h1);
    check("div_busy_done", {31'b0, busy}, 32'h0);

    // MT cancel
    dmu_hi = 32'h5555_0000; dmu_lo = 32'h0000_5555;
    issue(4'd6);                                    // E0
    tick();                                         // E1
    mthi = 1'b1; wdata = 32'h1234;
    tick();                                         // E2
    mthi = 1'b0;
    check("mt_busy", {31'b0, busy}, 32'h0);
    check("mt_hi", hi, 32'h1234);
    tick(); tick(); tick(); tick();                 // E3..E6
    check("mt_lo_keep", lo, 32'h3);
    check("mt_hi_keep", hi, 32'h1234);

    // Forwarding in the commit cycle
    dmu_hi = 32'hABCD; dmu_lo = 32'h77;
    issue(4'd5);                                    // E0
    tick(); tick(); tick(); tick();                 // E1..E4, cnt == 1
    mf_req = 1'b1; mf_sel = 1'b1; #1;
`ifdef HILO_FWD_EN
    check("fwd_stall", {31'b0, mf_stall}, 32'h0);
    check("fwd_data", mf_data, 32'hABCD);
`else
    check("nofwd_stall", {31'b0, mf_stall}, 32'h1);
    check("nofwd_data_old", mf_data, 32'h1234);
`endif
    tick();                                         // E5
    check("fwd_next_stall", {31'b0, mf_stall}, 32'h0);
    check("fwd_next_data", mf_data, 32'hABCD);
    mf_req = 1'b0;

    // Back-to-back: op 5 at E0, op 7 at E2, single commit at E7
    dmu_hi = 32'hAAAA; dmu_lo = 32'hBBBB;
    issue(4'd5);                                    // E0
    tick();                                         // E1
    issue(4'd7);                                    // E2
    tick(); tick(); tick();                         // E3..E5
    check("b2b_hi_e5", hi, 32'hABCD);
    tick();                                         // E6
    check("b2b_busy_e6", {31'b0, busy}, 32'h1);
    check("b2b_lo_e6", lo, 32'h77);
    tick();                                         // E7
    check("b2b_hi", hi, 32'hAAAA);
    check("b2b_lo", lo, 32'hBBBB);
    check("b2b_busy_done", {31'b0, busy}, 32'h0);

    // Non mult/div op is ignored
    issue(4'd3);
    check("badop_busy", {31'b0, busy}, 32'h0);

    // Stalled issue is not accepted
    dmu_stall = 1'b1;
    issue(4'd5);
    dmu_stall = 1'b0;
    check("stall_issue_busy", {31'b0, busy}, 32'h0);

    // MT plus commit: LO takes wdata, HI takes dmu value
    dmu_hi = 32'h4444; dmu_lo = 32'h8888;
    issue(4'd7);                                    // E0
    tick(); tick(); tick(); tick();                 // E1..E4
    mtlo = 1'b1; wdata = 32'h99; mf_req = 1'b1; mf_sel = 1'b0; #1;
`ifdef HILO_FWD_EN
    check("mtc_fwd_data", mf_data, 32'h99);
`else
    check("mtc_stall", {31'b0, mf_stall}, 32'h1);
`endif
    tick();                                         // E5
    mtlo = 1'b0; mf_req = 1'b0;
    check("mtc_lo", lo, 32'h99);
    check("mtc_hi", hi, 32'h4444);
    check("mtc_busy", {31'b0, busy}, 32'h0);

    // Reset mid-operation discards the later result
    dmu_hi = 32'h7777; dmu_lo = 32'h6666;
    issue(4'd5);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("rstmid_hi", hi, 32'h0);
    check("rstmid_lo", lo, 32'h0);
    check("rstmid_busy", {31'b0, busy}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
